// File: rtl/nibble_add_sched.sv
// Nibble-serial wide adder scheduler: arbitrates two requesters onto one shared
// external 4-bit adder and chains the carry through a register between nibbles.
module nibble_add_sched #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req0_valid,
    output logic                   req0_ready,
    input  logic [4*NIBBLES-1:0]   req0_a,
    input  logic [4*NIBBLES-1:0]   req0_b,
    input  logic                   req0_cin,
    input  logic                   req1_valid,
    output logic                   req1_ready,
    input  logic [4*NIBBLES-1:0]   req1_a,
    input  logic [4*NIBBLES-1:0]   req1_b,
    input  logic                   req1_cin,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic                   rsp_id,
    output logic [4*NIBBLES-1:0]   rsp_sum,
    output logic                   rsp_cout,
    output logic                   rsp_ovf,
    output logic [3:0]             add_a,
    output logic [3:0]             add_b,
    output logic                   add_cin,
    input  logic [3:0]             add_sum,
    input  logic                   add_cout
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES);
    localparam logic [IW-1:0] IDX_LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Two's-complement overflow: equal operand signs, differing result sign.
    function automatic logic ovf_f(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

    state_e          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            carry_q, carry_d;
    logic            last_grant_q, last_grant_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic            id_q, id_d;
    logic [W-1:0]    res_q, res_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            rsp_id_q, rsp_id_d;
    logic [W-1:0]    rsp_sum_q, rsp_sum_d;
    logic            rsp_cout_q, rsp_cout_d;
    logic            rsp_ovf_q, rsp_ovf_d;

    logic            grant_s;
    logic            accept_s;
    logic [IW+1:0]   nib_sel_s;
    logic [W-1:0]    final_sum_s;

    assign nib_sel_s   = {idx_q, 2'b00};
    assign final_sum_s = {add_sum, res_q[W-5:0]};

    // Round-robin grant; on contention the requester that did not win last goes.
    always_comb begin
        grant_s = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_s = ~last_grant_q;
        end else if (req1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    assign req0_ready = (state_q == ST_IDLE) && !rst && (grant_s == 1'b0);
    assign req1_ready = (state_q == ST_IDLE) && !rst && (grant_s == 1'b1);
    assign accept_s   = grant_s ? (req1_valid && req1_ready) : (req0_valid && req0_ready);

    // Sequencer next-state and shared-adder drive.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        carry_d      = carry_q;
        last_grant_d = last_grant_q;
        a_d          = a_q;
        b_d          = b_q;
        id_d         = id_q;
        res_d        = res_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_sum_d    = rsp_sum_q;
        rsp_cout_d   = rsp_cout_q;
        rsp_ovf_d    = rsp_ovf_q;
        add_a        = 4'h0;
        add_b        = 4'h0;
        add_cin      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    a_d          = grant_s ? req1_a : req0_a;
                    b_d          = grant_s ? req1_b : req0_b;
                    carry_d      = grant_s ? req1_cin : req0_cin;
                    id_d         = grant_s;
                    last_grant_d = grant_s;
                    idx_d        = {IW{1'b0}};
                    state_d      = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                add_a                  = a_q[nib_sel_s +: 4];
                add_b                  = b_q[nib_sel_s +: 4];
                add_cin                = carry_q;
                res_d[nib_sel_s +: 4]  = add_sum;
                carry_d                = add_cout;
                if (idx_q == IDX_LAST) begin
                    // Last nibble comes straight from the adder, so the
                    // response is assembled here rather than from res_q.
                    idx_d       = {IW{1'b0}};
                    state_d     = ST_DONE;
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = id_q;
                    rsp_sum_d   = final_sum_s;
                    rsp_cout_d  = add_cout;
                    rsp_ovf_d   = ovf_f(a_q[W-1], b_q[W-1], final_sum_s[W-1]);
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= {IW{1'b0}};
            carry_q      <= 1'b0;
            last_grant_q <= 1'b1;
            a_q          <= {W{1'b0}};
            b_q          <= {W{1'b0}};
            id_q         <= 1'b0;
            res_q        <= {W{1'b0}};
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_sum_q    <= {W{1'b0}};
            rsp_cout_q   <= 1'b0;
            rsp_ovf_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            carry_q      <= carry_d;
            last_grant_q <= last_grant_d;
            a_q          <= a_d;
            b_q          <= b_d;
            id_q         <= id_d;
            res_q        <= res_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_sum_q    <= rsp_sum_d;
            rsp_cout_q   <= rsp_cout_d;
            rsp_ovf_q    <= rsp_ovf_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;
    assign rsp_ovf   = rsp_ovf_q;

endmodule

// File: tb/tb_nibble_add_sched.sv
// Scoreboard bench for nibble_add_sched (NIBBLES=4) with a behavioural 4-bit adder.
module tb_nibble_add_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req0_cin;
    logic [15:0] req0_a, req0_b;
    logic        req1_valid, req1_ready, req1_cin;
    logic [15:0] req1_a, req1_b;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_cout, rsp_ovf;
    logic [15:0] rsp_sum;
    logic [3:0]  add_a, add_b, add_sum;
    logic        add_cin, add_cout;

    typedef struct packed {
        logic        id;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } rsp_t;

    rsp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'h0, add_cin};

    nibble_add_sched #(.NIBBLES(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
        .req0_b(req0_b), .req0_cin(req0_cin),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
        .req1_b(req1_b), .req1_cin(req1_cin),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: ready exclusivity every cycle, and scoreboard pop on each handshake.
    always @(negedge clk) begin
        rsp_t e;
        chk("ready_onehot", {31'd0, req0_ready & req1_ready}, 32'd0);
        if (rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_rsp", {13'd0, rsp_id, rsp_sum, rsp_cout, rsp_ovf}, 32'hFFFFFFFF);
            end else begin
                e = sb_q.pop_front();
                chk("rsp", {13'd0, rsp_id, rsp_sum, rsp_cout, rsp_ovf}, {13'd0, e});
            end
        end
    end

    task automatic issue(input logic id, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic push, input rsp_t exp);
        int n;
        if (id == 1'b0) begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_cin = cin;
        end else begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_cin = cin;
        end
        n = 0;
        @(negedge clk);
        while (!(id ? req1_ready : req0_ready) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("accept_timeout", 32'd1, 32'd0);
        else if (push) sb_q.push_back(exp);
        @(posedge clk);
        #1;
        if (id == 1'b0) begin
            req0_valid = 1'b0; req0_a = 16'hDEAD; req0_b = 16'hBEEF; req0_cin = 1'b1;
        end else begin
            req1_valid = 1'b0; req1_a = 16'hDEAD; req1_b = 16'hBEEF; req1_cin = 1'b1;
        end
    endtask

    task automatic wait_rsp(output int lat, output logic [3:0] cin_tr, output logic rdy_seen);
        lat = 0; cin_tr = 4'h0; rdy_seen = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            if (lat <= 4) cin_tr[lat-1] = add_cin;
            if (req0_ready || req1_ready) rdy_seen = 1'b1;
        end while (!rsp_valid && lat < 40);
    endtask

    initial begin
        int         lat, n;
        logic [3:0] ctr;
        logic       rdy;
        logic       gid;
        rsp_t       snap;

        rst = 1'b1; rsp_ready = 1'b1;
        req0_valid = 1'b0; req0_a = 16'h0; req0_b = 16'h0; req0_cin = 1'b0;
        req1_valid = 1'b0; req1_a = 16'h0; req1_b = 16'h0; req1_cin = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_readys", {30'd0, req0_ready, req1_ready}, 32'd0);
        chk("rst_rsp_fields", {13'd0, rsp_id, rsp_sum, rsp_cout, rsp_ovf}, 32'd0);
        chk("rst_add", {23'd0, add_a, add_b, add_cin}, 32'd0);
        @(posedge clk); #1; rst = 1'b0;

        // Basic add
        issue(1'b0, 16'h1234, 16'h0FCD, 1'b0, 1'b1, '{1'b0, 16'h2201, 1'b0, 1'b0});
        wait_rsp(lat, ctr, rdy);
        chk("basic_latency", lat, 32'd5);
        chk("basic_ready_busy", {31'd0, rdy}, 32'd0);

        // Signed overflow with carry-in
        @(posedge clk); #1;
        issue(1'b0, 16'h7FFF, 16'h0000, 1'b1, 1'b1, '{1'b0, 16'h8000, 1'b0, 1'b1});
        wait_rsp(lat, ctr, rdy);
        chk("ovf_latency", lat, 32'd5);

        // Full carry ripple from requester 1
        @(posedge clk); #1;
        issue(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b1, '{1'b1, 16'h0000, 1'b1, 1'b0});
        wait_rsp(lat, ctr, rdy);
        chk("ripple_latency", lat, 32'd5);
        chk("ripple_add_cin", {28'd0, ctr}, 32'h0000000E);

        // Fairness: both valid held for four grants
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_a = 16'h0001; req0_b = 16'h0000; req0_cin = 1'b0;
        req1_valid = 1'b1; req1_a = 16'h0001; req1_b = 16'h0001; req1_cin = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            @(negedge clk);
            while (!(req0_ready || req1_ready) && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (n >= 50) begin
                chk("fair_timeout", 32'd1, 32'd0);
            end else begin
                gid = req1_ready;
                chk("fair_grant", {31'd0, gid}, k % 2);
                sb_q.push_back(gid ? rsp_t'({1'b1, 16'h0002, 1'b0, 1'b0})
                                   : rsp_t'({1'b0, 16'h0001, 1'b0, 1'b0}));
            end
            @(posedge clk);
        end
        #1; req0_valid = 1'b0; req1_valid = 1'b0;
        wait_rsp(lat, ctr, rdy);
        chk("fair_last_latency", lat, 32'd5);

        // Backpressure, with requester 1 waiting throughout
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        issue(1'b0, 16'h1111, 16'h2222, 1'b0, 1'b1, '{1'b0, 16'h3333, 1'b0, 1'b0});
        req1_valid = 1'b1; req1_a = 16'h0005; req1_b = 16'h0003; req1_cin = 1'b0;
        wait_rsp(lat, ctr, rdy);
        chk("bp_latency", lat, 32'd5);
        chk("bp_ready_busy", {31'd0, rdy}, 32'd0);
        snap = {rsp_id, rsp_sum, rsp_cout, rsp_ovf};
        chk("bp_value", {13'd0, snap}, {13'd0, 1'b0, 16'h3333, 1'b0, 1'b0});
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("bp_stable", {12'd0, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf},
                {12'd0, 1'b1, snap});
            chk("bp_readys", {30'd0, req0_ready, req1_ready}, 32'd0);
        end
        @(posedge clk); #1; rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_release_valid", {31'd0, rsp_valid}, 32'd0);
        chk("bp_next_ready", {30'd0, req0_ready, req1_ready}, 32'd1);
        if (req1_ready) sb_q.push_back('{1'b1, 16'h0008, 1'b0, 1'b0});
        @(posedge clk); #1; req1_valid = 1'b0;
        wait_rsp(lat, ctr, rdy);
        chk("bp_next_latency", lat, 32'd5);

        // Reset during RUN nibble 2
        @(posedge clk); #1;
        issue(1'b1, 16'h1234, 16'h1111, 1'b0, 1'b0, '{1'b0, 16'h0000, 1'b0, 1'b0});
        @(negedge clk);
        @(negedge clk);
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        req0_valid = 1'b1; req0_a = 16'h0002; req0_b = 16'h0003; req0_cin = 1'b0;
        req1_valid = 1'b1; req1_a = 16'h0009; req1_b = 16'h0009; req1_cin = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("mid_rst_fields", {13'd0, rsp_id, rsp_sum, rsp_cout, rsp_ovf}, 32'd0);
        chk("mid_rst_add", {23'd0, add_a, add_b, add_cin}, 32'd0);
        chk("mid_rst_grant", {30'd0, req0_ready, req1_ready}, 32'd2);
        if (req0_ready) sb_q.push_back('{1'b0, 16'h0005, 1'b0, 1'b0});
        @(posedge clk); #1; req0_valid = 1'b0; req1_valid = 1'b0;
        wait_rsp(lat, ctr, rdy);
        chk("post_rst_latency", lat, 32'd5);

        repeat (4) @(negedge clk);
        chk("sb_drained", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/nibble_add_sched.md
Name: nibble_add_sched

Overview:
Sequencer and arbiter that shares one 4-bit ripple-carry adder (rip_adder) between two requesters. It performs wide additions nibble-serially, least-significant nibble first, and chains the carry through an internal register between nibbles. It sits between two client blocks (valid/ready request channels) and a single response channel that returns the sum, carry-out, signed overflow and requester id. The adder itself is instantiated outside this block; the block drives and samples it through the add_* ports.

Parameters:
NIBBLES, 4, operand width in nibbles; W = 4*NIBBLES. Legal range 2..16.

Ports:
clk  in  1  single clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation is accepted this cycle
req0_a  in  W  operand A
req0_b  in  W  operand B
req0_cin  in  1  carry-in
req1_valid, req1_ready, req1_a, req1_b, req1_cin  as req0, for requester 1
rsp_valid  out  1  result available
rsp_ready  in  1  consumer accepts the result
rsp_id  out  1  requester that issued the result (0/1)
rsp_sum  out  W  A+B+cin modulo 2^W
rsp_cout  out  1  carry-out of bit W-1
rsp_ovf  out  1  two's-complement overflow
add_a  out  4  nibble of A to the shared adder
add_b  out  4  nibble of B to the shared adder
add_cin  out  1  carry into the shared adder
add_sum  in  4  adder sum (combinational from add_*)
add_cout  in  1  adder carry-out

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- FSM states: IDLE, RUN, DONE.
- Reset (synchronous, rst=1 at an edge): state=IDLE; rsp_valid=0; rsp_id=0; rsp_sum=0; rsp_cout=0; rsp_ovf=0; nibble index=0; carry register=0; last_grant=1, so requester 0 wins the first contest. Reset overrides everything, including mid-RUN or DONE. An in-flight operation is discarded without any response.
- Arbitration (IDLE only): the grant is combinational from the two valids and last_grant.
  - Only one valid: that requester is granted.
  - Both valid: the requester that is not last_grant is granted.
  - reqX_ready = (state==IDLE) && grant==X. At most one ready is high per cycle. Both readys are 0 in RUN and DONE and during reset.
- Accept (cycle 0): on valid&&ready, register A, B, the id and the carry register <= cin; last_grant <= id; index <= 0; go to RUN.
- RUN (cycles 1..NIBBLES): add_a/add_b = nibble[index] of the registered A/B; add_cin = carry register.
  - Each edge: store add_sum into result nibble[index]; carry register <= add_cout; index++.
  - After nibble NIBBLES-1, go to DONE with rsp_cout = final add_cout.
- DONE: rsp_valid=1 starting at cycle NIBBLES+1 after accept.
  - rsp_ovf = (A[W-1]==B[W-1]) && (rsp_sum[W-1]!=A[W-1]).
  - rsp_* stay stable while rsp_valid && !rsp_ready.
  - When rsp_ready is high, the response is consumed and the FSM returns to IDLE with rsp_valid=0 next cycle.
  - No bypass: throughput is 1 operation per NIBBLES+2 cycles minimum.
- add_a, add_b and add_cin are driven to 0 outside RUN.
- Request inputs are ignored except in the accept cycle; operands may change after acceptance.
- rsp_sum/rsp_cout/rsp_ovf retain their last values after consumption until the next DONE. Only rsp_valid qualifies them.
- Wrap-around: the sum is modulo 2^W. Overflow of the carry chain is reported only via rsp_cout.

Test Plan:
(All scenarios use NIBBLES=4. Cycle 0 is the accept cycle.)
1. Basic add: req0 a=0x1234 b=0x0FCD cin=0, rsp_ready=1 → rsp_valid at cycle 5; sum=0x2201, cout=0, ovf=0, id=0; req0_ready high only in cycle 0.
2. Full carry ripple: req1 a=0xFFFF b=0x0001 cin=0 → sum=0x0000, cout=1, ovf=0, id=1; add_cin=1 on nibbles 1-3.
3. Signed overflow with cin: req0 a=0x7FFF b=0x0000 cin=1 → sum=0x8000, cout=0, ovf=1.
4. Fairness: both valids held high for 4 ops with a=0x0001, b=id → grant order 0,1,0,1; rsp_id matches; sums 0x0001, 0x0002 alternating; never two readys in one cycle.
5. Backpressure: rsp_ready=0 for 3 cycles after rsp_valid → rsp_* stable, both readys 0; rsp_ready=1 → IDLE next cycle, then the next accept.
6. Reset mid-operation: rst=1 during RUN nibble 2 → next cycle rsp_valid=0, rsp_* zero, add_* zero, no response emitted; with both valid after reset, req0 is granted first.
